// File: rtl/puf_eval_ctrl.sv
// RO-PUF evaluation sequencer: CLEAR/RUN/SETTLE/COMPARE per bit; done in cycle N_BITS*(WIN+SETTLE+2)+1 after start.
// No backpressure: start is taken only in IDLE, and abort returns to IDLE from any state.
module puf_eval_ctrl #(
  parameter int N_BITS        = 8,
  parameter int SEL_W         = 5,
  parameter int CNT_W         = 8,
  parameter int WIN_CYCLES    = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [SEL_W-1:0]            challenge,
  input  logic [CNT_W-1:0]            cnt_a,
  input  logic [CNT_W-1:0]            cnt_b,
  output logic                        ro_en,
  output logic                        cnt_clr,
  output logic [SEL_W-1:0]            ro_sel,
  output logic                        busy,
  output logic                        done,
  output logic [N_BITS-1:0]           response,
  output logic [$clog2(N_BITS+1)-1:0] tie_cnt
);

  localparam int TIE_W   = $clog2(N_BITS + 1);
  localparam int K_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    SETTLE  = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   base_q, base_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [SEL_W-1:0]   ro_sel_q, ro_sel_d;
  logic [N_BITS-1:0]  response_q, response_d;
  logic [TIE_W-1:0]   tie_cnt_q, tie_cnt_d;
  logic               ro_en_q, ro_en_d;
  logic               cnt_clr_q, cnt_clr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    k_d        = k_q;
    tmr_d      = tmr_q;
    ro_sel_d   = ro_sel_q;
    response_d = response_q;
    tie_cnt_d  = tie_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          base_d     = challenge;
          k_d        = '0;
          ro_sel_d   = challenge;
          response_d = '0;
          tie_cnt_d  = '0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        tmr_d   = TMR_W'(WIN_CYCLES - 1);
        state_d = RUN;
      end
      RUN: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          state_d = COMPARE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      COMPARE: begin
        // Raw unsigned compare; a wrapped counter simply reads as small.
        response_d[k_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b) begin
          tie_cnt_d = tie_cnt_q + TIE_W'(1);
        end
        if (k_q == K_W'(N_BITS - 1)) begin
          state_d = DONE;
        end else begin
          k_d      = k_q + K_W'(1);
          ro_sel_d = base_q + SEL_W'(k_q + K_W'(1));
          state_d  = CLEAR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over any in-flight update so partial results stay as they were.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      k_d        = k_q;
      tmr_d      = '0;
      response_d = response_q;
      tie_cnt_d  = tie_cnt_q;
    end

    ro_en_d   = (state_d == RUN);
    cnt_clr_d = (state_d == CLEAR);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      k_q        <= '0;
      tmr_q      <= '0;
      ro_sel_q   <= '0;
      response_q <= '0;
      tie_cnt_q  <= '0;
      ro_en_q    <= 1'b0;
      cnt_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      k_q        <= k_d;
      tmr_q      <= tmr_d;
      ro_sel_q   <= ro_sel_d;
      response_q <= response_d;
      tie_cnt_q  <= tie_cnt_d;
      ro_en_q    <= ro_en_d;
      cnt_clr_q  <= cnt_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ro_en    = ro_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign ro_sel   = ro_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;
  assign tie_cnt  = tie_cnt_q;

endmodule
